// File: rtl/test_sequencer.sv
// test_sequencer: launches board self-test engines one at a time or back-to-back,
// enforces a per-test timeout and accumulates pass/fail/timeout masks.
module test_sequencer #(
   parameter int unsigned NTESTS         = 4,
   parameter int unsigned INIT_PULSE     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 7000000,
   parameter int unsigned LED_DIV        = 1750000,
   localparam int unsigned SW = (NTESTS > 1) ? $clog2(NTESTS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_one,
   input  logic [SW-1:0]     test_sel,
   input  logic              start_all,
   input  logic              abort,
   output logic [NTESTS-1:0] test_init,
   input  logic [NTESTS-1:0] test_progress,
   input  logic [NTESTS-1:0] test_result,
   output logic              busy,
   output logic [SW-1:0]     current,
   output logic [NTESTS-1:0] pass_mask,
   output logic [NTESTS-1:0] fail_mask,
   output logic [NTESTS-1:0] timeout_mask,
   output logic              done,
   output logic              led
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned PW = (INIT_PULSE > 1) ? $clog2(INIT_PULSE) : 1;
   localparam int unsigned BW = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;

   localparam logic [CW-1:0] TMO_LOAD   = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [PW-1:0] PULSE_LOAD = PW'(INIT_PULSE - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(LED_DIV - 1);
   localparam logic [SW-1:0] LAST_CH    = SW'(NTESTS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_WAIT_START,
      S_RUN,
      S_NEXT
   } state_t;

   state_t            state_q, state_d;
   logic [SW-1:0]     current_q, current_d;
   logic              all_mode_q, all_mode_d;
   logic [PW-1:0]     pulse_q, pulse_d;
   logic [CW-1:0]     tmo_q, tmo_d;
   logic [NTESTS-1:0] pass_q, pass_d;
   logic [NTESTS-1:0] fail_q, fail_d;
   logic [NTESTS-1:0] tout_q, tout_d;
   logic [NTESTS-1:0] init_q, init_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              led_q, led_d;
   logic [BW-1:0]     blink_q, blink_d;

   logic [NTESTS-1:0] cur_bit;
   logic [NTESTS-1:0] nxt_bit;
   logic              sel_ok;
   logic              prog_cur;
   logic              res_cur;

   assign cur_bit  = NTESTS'(1) << current_q;
   assign sel_ok   = 32'(test_sel) < NTESTS;
   assign prog_cur = |(test_progress & cur_bit);
   assign res_cur  = |(test_result & cur_bit);

   // Next-state, mask and output computation; outputs are registered from next state.
   always_comb begin
      state_d    = state_q;
      current_d  = current_q;
      all_mode_d = all_mode_q;
      pulse_d    = pulse_q;
      tmo_d      = tmo_q;
      pass_d     = pass_q;
      fail_d     = fail_q;
      tout_d     = tout_q;
      done_d     = 1'b0;
      led_d      = led_q;
      blink_d    = blink_q;
      nxt_bit    = '0;

      case (state_q)
         S_IDLE: begin
            if (start_all) begin
               current_d  = '0;
               all_mode_d = 1'b1;
               pass_d     = '0;
               fail_d     = '0;
               tout_d     = '0;
               state_d    = S_INIT;
            end else if (start_one && sel_ok) begin
               current_d  = test_sel;
               all_mode_d = 1'b0;
               state_d    = S_INIT;
            end
         end
         S_INIT: begin
            if (pulse_q == '0) begin
               tmo_d   = TMO_LOAD;
               state_d = S_WAIT_START;
            end else begin
               pulse_d = pulse_q - PW'(1);
            end
         end
         S_WAIT_START: begin
            if (tmo_q == '0) begin
               tout_d  = tout_q | cur_bit;
               state_d = S_NEXT;
            end else begin
               tmo_d = tmo_q - CW'(1);
               if (prog_cur) begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            // Completion wins over a timeout landing in the same cycle.
            if (!prog_cur) begin
               if (res_cur) begin
                  pass_d = pass_q | cur_bit;
               end else begin
                  fail_d = fail_q | cur_bit;
               end
               state_d = S_NEXT;
            end else if (tmo_q == '0) begin
               tout_d  = tout_q | cur_bit;
               state_d = S_NEXT;
            end else begin
               tmo_d = tmo_q - CW'(1);
            end
         end
         S_NEXT: begin
            if (all_mode_q && (current_q < LAST_CH)) begin
               current_d = current_q + SW'(1);
               state_d   = S_INIT;
            end else begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort discards any outcome decided this cycle.
      if (abort && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         current_d = current_q;
         pass_d    = pass_q;
         fail_d    = fail_q;
         tout_d    = tout_q;
         done_d    = 1'b1;
      end

      nxt_bit = NTESTS'(1) << current_d;

      if ((state_d == S_INIT) && (state_q != S_INIT)) begin
         pulse_d = PULSE_LOAD;
         pass_d  = pass_d & ~nxt_bit;
         fail_d  = fail_d & ~nxt_bit;
         tout_d  = tout_d & ~nxt_bit;
      end

      init_d = (state_d == S_INIT) ? nxt_bit : '0;
      busy_d = (state_d != S_IDLE);

      // Busy blink restarts from 1 each launch from idle; idle shows any failure.
      if (state_d == S_IDLE) begin
         led_d   = |(fail_d | tout_d);
         blink_d = '0;
      end else if (state_q == S_IDLE) begin
         led_d   = 1'b1;
         blink_d = '0;
      end else if (blink_q == BLINK_LAST) begin
         led_d   = ~led_q;
         blink_d = '0;
      end else begin
         blink_d = blink_q + BW'(1);
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         current_q  <= '0;
         all_mode_q <= 1'b0;
         pulse_q    <= '0;
         tmo_q      <= '0;
         pass_q     <= '0;
         fail_q     <= '0;
         tout_q     <= '0;
         init_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         led_q      <= 1'b0;
         blink_q    <= '0;
      end else begin
         state_q    <= state_d;
         current_q  <= current_d;
         all_mode_q <= all_mode_d;
         pulse_q    <= pulse_d;
         tmo_q      <= tmo_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         tout_q     <= tout_d;
         init_q     <= init_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         led_q      <= led_d;
         blink_q    <= blink_d;
      end
   end

   assign test_init    = init_q;
   assign busy         = busy_q;
   assign current      = current_q;
   assign pass_mask    = pass_q;
   assign fail_mask    = fail_q;
   assign timeout_mask = tout_q;
   assign done         = done_q;
   assign led          = led_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer with test-engine model and launch/outcome scoreboard.
module tb_test_sequencer;

   localparam int INIT_PULSE = 4;

   typedef struct packed {
      logic [3:0] p;
      logic [3:0] f;
      logic [3:0] t;
   } out_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_one, start_all, abort;
   logic [1:0] test_sel;
   logic [3:0] test_init, pass_mask, fail_mask, timeout_mask;
   logic [3:0] progress = '0;
   logic [3:0] result   = '0;
   logic       busy, done, led;
   logic [1:0] current;

   logic       start5, abort5;
   logic [2:0] sel5, current5;
   logic [4:0] init5, pass5, fail5, tout5;
   logic       busy5, done5, led5;

   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;

   int   exp_ch[$];
   out_t exp_out[$];

   int   m_dly[4], m_hold[4], m_cnt[4], m_phase[4];
   logic m_res[4], m_never[4], m_prev[4];
   logic model_kill = 1'b0;
   logic skip_width = 1'b0;

   always #5 clk = ~clk;

   test_sequencer #(.NTESTS(4), .INIT_PULSE(INIT_PULSE), .TIMEOUT_CYCLES(50), .LED_DIV(8)) dut (
      .clk(clk), .rst(rst), .start_one(start_one), .test_sel(test_sel), .start_all(start_all),
      .abort(abort), .test_init(test_init), .test_progress(progress), .test_result(result),
      .busy(busy), .current(current), .pass_mask(pass_mask), .fail_mask(fail_mask),
      .timeout_mask(timeout_mask), .done(done), .led(led));

   test_sequencer #(.NTESTS(5), .INIT_PULSE(INIT_PULSE), .TIMEOUT_CYCLES(50), .LED_DIV(8)) dut5 (
      .clk(clk), .rst(rst), .start_one(start5), .test_sel(sel5), .start_all(1'b0),
      .abort(abort5), .test_init(init5), .test_progress(5'b0), .test_result(5'b0),
      .busy(busy5), .current(current5), .pass_mask(pass5), .fail_mask(fail5),
      .timeout_mask(tout5), .done(done5), .led(led5));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input int ch, input int dly, input int hold, input logic res, input logic never);
      m_dly[ch] = dly; m_hold[ch] = hold; m_res[ch] = res; m_never[ch] = never;
   endtask

   task automatic pulse_one(input logic [1:0] sel);
      start_one = 1'b1; test_sel = sel; @(negedge clk); start_one = 1'b0;
   endtask

   task automatic pulse_all();
      start_all = 1'b1; @(negedge clk); start_all = 1'b0;
   endtask

   task automatic pulse5(input logic [2:0] sel);
      start5 = 1'b1; sel5 = sel; @(negedge clk); start5 = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
      check(tag, {31'b0, busy}, 32'd0);
   endtask

   // Test-engine model: progress rises m_dly cycles after init falls, held m_hold cycles.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (model_kill) begin
            m_phase[i] = 0; progress[i] = 1'b0;
         end else if (m_prev[i] && !test_init[i]) begin
            m_phase[i] = m_never[i] ? 0 : 1; m_cnt[i] = m_dly[i];
         end else if (m_phase[i] == 1) begin
            if (m_cnt[i] <= 1) begin
               progress[i] = 1'b1; result[i] = m_res[i]; m_phase[i] = 2; m_cnt[i] = m_hold[i];
            end else m_cnt[i]--;
         end else if (m_phase[i] == 2) begin
            if (m_cnt[i] <= 1) begin progress[i] = 1'b0; m_phase[i] = 0; end
            else m_cnt[i]--;
         end
         m_prev[i] = test_init[i];
      end
   end

   // Launch scoreboard: order of init strobes and their width.
   logic [3:0] mon_prev = '0;
   int         mon_width = 0;
   int         mon_ch;
   always @(negedge clk) begin
      if (test_init != 4'b0 && mon_prev == 4'b0) begin
         check("launch_expected", {31'b0, exp_ch.size() != 0}, 32'd1);
         if (exp_ch.size() != 0) begin
            mon_ch = exp_ch.pop_front();
            check("launch_channel", {28'b0, test_init}, 32'd1 << mon_ch);
         end
      end
      if (test_init != 4'b0) mon_width++;
      if (test_init == 4'b0 && mon_prev != 4'b0) begin
         if (!skip_width) check("init_width", mon_width, INIT_PULSE);
         mon_width = 0;
      end
      mon_prev = test_init;
   end

   // Outcome scoreboard: masks compared on every done pulse.
   logic done_prev = 1'b0;
   out_t mon_o;
   always @(negedge clk) begin
      if (done) begin
         n_done++;
         check("done_single_cycle", {31'b0, done_prev}, 32'd0);
         check("done_expected", {31'b0, exp_out.size() != 0}, 32'd1);
         if (exp_out.size() != 0) begin
            mon_o = exp_out.pop_front();
            check("done_pass_mask", {28'b0, pass_mask}, {28'b0, mon_o.p});
            check("done_fail_mask", {28'b0, fail_mask}, {28'b0, mon_o.f});
            check("done_tmo_mask", {28'b0, timeout_mask}, {28'b0, mon_o.t});
            check("done_busy_low", {31'b0, busy}, 32'd0);
         end
      end
      done_prev = done;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int d0;
      rst = 1'b1; start_one = 1'b0; start_all = 1'b0; abort = 1'b0; test_sel = '0;
      start5 = 1'b0; abort5 = 1'b0; sel5 = '0;
      for (int i = 0; i < 4; i++) begin
         cfg(i, 2, 5, 1'b1, 1'b0); m_phase[i] = 0; m_cnt[i] = 0; m_prev[i] = 1'b0;
      end
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_init", {28'b0, test_init}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_masks", {20'b0, pass_mask, fail_mask, timeout_mask}, 32'd0);
      check("rst_led", {31'b0, led}, 32'd0);
      check("rst_current", {30'b0, current}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single pass on channel 2
      cfg(2, 3, 10, 1'b1, 1'b0);
      exp_ch.push_back(2);
      exp_out.push_back(out_t'{4'b0100, 4'b0000, 4'b0000});
      d0 = n_done;
      pulse_one(2'd2);
      check("one_busy", {31'b0, busy}, 32'd1);
      check("one_init", {28'b0, test_init}, 32'h4);
      check("one_led_busy", {31'b0, led}, 32'd1);
      wait_idle("one_idle", 200);
      @(negedge clk);
      check("one_done_count", n_done - d0, 32'd1);
      check("one_done_low", {31'b0, done}, 32'd0);
      check("one_led_idle", {31'b0, led}, 32'd0);
      check("one_current_hold", {30'b0, current}, 32'd2);

      // Run-all with mixed results 1,0,1,1
      cfg(0, 2, 5, 1'b1, 1'b0); cfg(1, 2, 5, 1'b0, 1'b0);
      cfg(2, 2, 5, 1'b1, 1'b0); cfg(3, 2, 5, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) exp_ch.push_back(i);
      exp_out.push_back(out_t'{4'b1101, 4'b0010, 4'b0000});
      d0 = n_done;
      pulse_all();
      check("all_init0", {28'b0, test_init}, 32'h1);
      check("all_led_start", {31'b0, led}, 32'd1);
      repeat (7) @(negedge clk);
      check("blink_hold", {31'b0, led}, 32'd1);
      @(negedge clk);
      check("blink_toggle", {31'b0, led}, 32'd0);
      wait_idle("all_idle", 400);
      @(negedge clk);
      check("all_done_count", n_done - d0, 32'd1);
      check("all_led_idle", {31'b0, led}, 32'd1);
      check("all_current", {30'b0, current}, 32'd3);
      check("all_launch_drained", exp_ch.size(), 32'd0);

      // Timeout on channel 1
      cfg(1, 2, 5, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) exp_ch.push_back(i);
      exp_out.push_back(out_t'{4'b1101, 4'b0000, 4'b0010});
      pulse_all();
      n = 0;
      while (!test_init[1] && n < 300) begin @(negedge clk); n++; end
      check("tmo_ch1_launch", {31'b0, test_init[1]}, 32'd1);
      n = 0;
      while (test_init[1] && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (!timeout_mask[1] && n < 200) begin @(negedge clk); n++; end
      check("tmo_latency", n, 32'd50);
      check("tmo_not_fail", {31'b0, fail_mask[1]}, 32'd0);
      wait_idle("tmo_idle", 400);
      @(negedge clk);
      check("tmo_led_idle", {31'b0, led}, 32'd1);
      cfg(1, 2, 5, 1'b1, 1'b0);

      // Abort during RUN of channel 2
      for (int i = 0; i < 4; i++) cfg(i, 2, 20, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) exp_ch.push_back(i);
      exp_out.push_back(out_t'{4'b0011, 4'b0000, 4'b0000});
      pulse_all();
      n = 0;
      while (!progress[2] && n < 400) begin @(negedge clk); n++; end
      check("abort_reach_run", {31'b0, progress[2]}, 32'd1);
      repeat (2) @(negedge clk);
      abort = 1'b1; @(negedge clk); abort = 1'b0;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd1);
      check("abort_init", {28'b0, test_init}, 32'd0);
      check("abort_pass", {28'b0, pass_mask}, 32'h3);
      check("abort_current", {30'b0, current}, 32'd2);
      model_kill = 1'b1; @(negedge clk); model_kill = 1'b0;
      repeat (3) @(negedge clk);

      // Single run clears only its own channel bits
      cfg(0, 2, 5, 1'b0, 1'b0);
      exp_ch.push_back(0);
      exp_out.push_back(out_t'{4'b0010, 4'b0001, 4'b0000});
      pulse_one(2'd0);
      wait_idle("clr_idle", 200);
      @(negedge clk);
      check("clr_led_idle", {31'b0, led}, 32'd1);

      // start_all priority, and starts while busy ignored
      for (int i = 0; i < 4; i++) cfg(i, 2, 3, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) exp_ch.push_back(i);
      exp_out.push_back(out_t'{4'b1111, 4'b0000, 4'b0000});
      start_all = 1'b1; start_one = 1'b1; test_sel = 2'd2;
      @(negedge clk);
      start_all = 1'b0; start_one = 1'b0;
      check("prio_init", {28'b0, test_init}, 32'h1);
      check("prio_current", {30'b0, current}, 32'd0);
      repeat (10) @(negedge clk);
      pulse_one(2'd3);
      pulse_all();
      wait_idle("prio_idle", 400);
      @(negedge clk);
      check("prio_current_end", {30'b0, current}, 32'd3);
      check("prio_launch_drained", exp_ch.size(), 32'd0);

      // Out-of-range test_sel on a 5-channel instance
      pulse5(3'd5);
      check("sel5_busy", {31'b0, busy5}, 32'd0);
      check("sel5_init", {27'b0, init5}, 32'd0);
      pulse5(3'd7);
      @(negedge clk);
      check("sel7_busy", {31'b0, busy5}, 32'd0);
      pulse5(3'd4);
      check("sel4_busy", {31'b0, busy5}, 32'd1);
      check("sel4_init", {27'b0, init5}, 32'h10);
      check("sel4_current", {29'b0, current5}, 32'd4);
      abort5 = 1'b1; @(negedge clk); abort5 = 1'b0;
      check("abort5_busy", {31'b0, busy5}, 32'd0);
      check("abort5_done", {31'b0, done5}, 32'd1);

      // Reset during INIT
      exp_ch.push_back(0);
      skip_width = 1'b1;
      pulse_one(2'd0);
      check("rinit_init", {28'b0, test_init}, 32'h1);
      rst = 1'b1; @(negedge clk);
      check("rinit_init_drop", {28'b0, test_init}, 32'd0);
      check("rinit_masks", {20'b0, pass_mask, fail_mask, timeout_mask}, 32'd0);
      check("rinit_led", {31'b0, led}, 32'd0);
      check("rinit_busy", {31'b0, busy}, 32'd0);
      check("rinit_current", {30'b0, current}, 32'd0);
      rst = 1'b0; model_kill = 1'b1; @(negedge clk); model_kill = 1'b0; skip_width = 1'b0;
      repeat (3) @(negedge clk);
      check("rinit_stay_idle", {31'b0, busy}, 32'd0);

      check("end_launch_queue", exp_ch.size(), 32'd0);
      check("end_outcome_queue", exp_out.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
